deser_align: RTL and testbench

- Parametrised successor to the 8-bit deserializer.
- Converts an MSB-first serial bit stream plus a per-bit control flag (DK) into WIDTH-bit parallel words.
- Achieves word alignment by hunting for a comma character; tracks lock and recovers from misalignment automatically.
- Sits between the serial link receiver and the downstream word/control decoder of the serdes path.

---
 rtl/deser_pkg.sv | 17 +
 rtl/deser_shift_det.sv | 28 ++
 rtl/deser_align.sv | 154 +++++++++++++++
 tb/tb_deser_align.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and constants for the comma-aligned deserializer.
package deser_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      CHECK = 2'd1,
      SYNC  = 2'd2
   } state_t;

   localparam logic [7:0] K28_5_LSB8 = 8'hBC;

   // Bits needed to hold a counter that runs 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/deser_shift_det.sv
// Serial-to-parallel shifter with comma detection on the word being completed this cycle.
module deser_shift_det
   import deser_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] COMMA = WIDTH'(K28_5_LSB8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data,
   input  logic             dk,
   output logic [WIDTH-1:0] cand,
   output logic             comma_hit
);

   // The oldest bit drops out on the same edge the candidate word is formed,
   // so only WIDTH-1 bits ever need to be stored.
   logic [WIDTH-2:0] sr_p0;

   assign cand      = {sr_p0, data};
   assign comma_hit = dk && (cand == COMMA);

   always_ff @(posedge clk) begin
      if (reset) sr_p0 <= '0;
      else       sr_p0 <= cand[WIDTH-2:0];
   end

endmodule

// File: rtl/deser_align.sv
// Comma-aligned deserializer: HUNT/CHECK/SYNC framing FSM with registered word outputs.
// Optional DESER_ERRCNT_EN adds err_cnt, a saturating count of loss-of-lock events.
module deser_align
   import deser_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] COMMA        = WIDTH'(K28_5_LSB8),
   parameter int               LOCK_CNT     = 3,
   parameter int               MISALIGN_MAX = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data,
   input  logic             DK,
   output logic [WIDTH-1:0] out,
   output logic             out_DK,
   output logic             out_valid,
   output logic             locked,
   output logic             realign
`ifdef DESER_ERRCNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   localparam int BW = cnt_w(WIDTH - 1);
   localparam int HW = cnt_w(LOCK_CNT);
   localparam int MW = cnt_w(MISALIGN_MAX);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [HW-1:0] LOCK_LAST = HW'(LOCK_CNT - 1);
   localparam logic [HW-1:0] HITS_MAX  = HW'(LOCK_CNT);
   localparam logic [MW-1:0] MISS_LAST = MW'(MISALIGN_MAX - 1);

   state_t           state, state_nx;
   logic [BW-1:0]    bit_cnt, bit_cnt_d;
   logic [HW-1:0]    hits, hits_d;
   logic [MW-1:0]    misses, misses_d;
   logic [WIDTH-1:0] cand;
   logic             comma_hit;
   logic             boundary;
   logic             realign_d;
   logic             emit_d;

   deser_shift_det #(
      .WIDTH (WIDTH),
      .COMMA (COMMA)
   ) u_shift_det (
      .clk       (clk),
      .reset     (reset),
      .data      (data),
      .dk        (DK),
      .cand      (cand),
      .comma_hit (comma_hit)
   );

   assign boundary = (bit_cnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= HUNT;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         HUNT:    if (comma_hit) state_nx = (LOCK_CNT == 1) ? SYNC : CHECK;
         CHECK:   if (comma_hit && boundary && (hits >= LOCK_LAST)) state_nx = SYNC;
         // Lock loss re-anchors on the offending comma, so HUNT is passed straight through.
         SYNC:    if (comma_hit && !boundary && (misses >= MISS_LAST)) state_nx = CHECK;
         default: state_nx = HUNT;
      endcase
   end

   always_comb begin
      realign_d = 1'b0;
      emit_d    = 1'b0;
      bit_cnt_d = boundary ? '0 : bit_cnt + 1'b1;
      hits_d    = hits;
      misses_d  = misses;
      case (state)
         HUNT: begin
            if (comma_hit) begin
               realign_d = 1'b1;
               emit_d    = (LOCK_CNT == 1);
            end
         end
         CHECK: begin
            if (comma_hit) begin
               if (!boundary) begin
                  realign_d = 1'b1;
               end else begin
                  if (hits < HITS_MAX) hits_d = hits + 1'b1;
                  emit_d = (hits >= LOCK_LAST);
               end
            end
         end
         SYNC: begin
            emit_d = boundary;
            if (comma_hit) begin
               if (boundary) begin
                  misses_d = '0;
               end else if (misses >= MISS_LAST) begin
                  misses_d  = '0;
                  realign_d = 1'b1;
               end else begin
                  misses_d = misses + 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (realign_d) begin
         bit_cnt_d = '0;
         hits_d    = HW'(1);
      end
   end

   // Output stage: word and flags registered on the edge of the word's last bit
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt   <= '0;
         hits      <= '0;
         misses    <= '0;
         out       <= '0;
         out_DK    <= 1'b0;
         out_valid <= 1'b0;
         locked    <= 1'b0;
         realign   <= 1'b0;
      end else begin
         bit_cnt   <= bit_cnt_d;
         hits      <= hits_d;
         misses    <= misses_d;
         out_valid <= emit_d;
         locked    <= (state_nx == SYNC);
         realign   <= realign_d;
         if (emit_d) begin
            out    <= cand;
            out_DK <= DK;
         end
      end
   end

`ifdef DESER_ERRCNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset)                                  err_cnt <= '0;
      else if (state == SYNC && state_nx != SYNC) err_cnt <= sat_inc8(err_cnt);
   end
`endif

endmodule

// File: tb/tb_deser_align.sv
// Bench for deser_align: directed scenarios plus random traffic against a phase-based reference model.
module tb_deser_align;

   localparam int         W    = 8;
   localparam logic [7:0] K    = 8'hBC;
   localparam int         LCK  = 3;
   localparam int         MMAX = 2;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         data  = 1'b0;
   logic         DK    = 1'b0;
   logic [W-1:0] out;
   logic         out_DK, out_valid, locked, realign;
`ifdef DESER_ERRCNT_EN
   logic [7:0]   err_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: alignment tracked as the edge index where a word starts.
   int         m_word, m_mode, m_e, m_anchor, m_hits, m_miss, m_err;
   logic [7:0] x_out;
   logic       x_dk, x_valid, x_locked, x_realign;

   deser_align #(
      .WIDTH        (W),
      .COMMA        (K),
      .LOCK_CNT     (LCK),
      .MISALIGN_MAX (MMAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .data      (data),
      .DK        (DK),
      .out       (out),
      .out_DK    (out_DK),
      .out_valid (out_valid),
      .locked    (locked),
      .realign   (realign)
`ifdef DESER_ERRCNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_word = 0; m_mode = 0; m_e = 0; m_anchor = 0;
      m_hits = 0; m_miss = 0; m_err = 0;
      x_out = '0; x_dk = 1'b0; x_valid = 1'b0; x_locked = 1'b0; x_realign = 1'b0;
   endtask

   task automatic model_step(input logic d, input logic k);
      int cand;
      bit hit, bnd, re, emit;
      cand = (m_word * 2 + int'(d)) % 256;
      hit  = (cand == int'(K)) && (k == 1'b1);
      bnd  = ((m_e - m_anchor) % W) == (W - 1);
      re   = 1'b0;
      emit = 1'b0;
      case (m_mode)
         0: if (hit) begin re = 1'b1; m_mode = 1; end
         1: if (hit) begin
               if (!bnd) re = 1'b1;
               else begin
                  m_hits++;
                  if (m_hits >= LCK) begin m_mode = 2; emit = 1'b1; end
               end
            end
         default: begin
            emit = bnd;
            if (hit) begin
               if (bnd) m_miss = 0;
               else begin
                  m_miss++;
                  if (m_miss >= MMAX) begin
                     m_miss = 0; m_mode = 1; re = 1'b1;
                     if (m_err < 255) m_err++;
                  end
               end
            end
         end
      endcase
      if (re) begin m_hits = 1; m_anchor = m_e + 1; end
      if (emit) begin x_out = 8'(cand); x_dk = k; end
      x_valid   = emit;
      x_realign = re;
      x_locked  = (m_mode == 2);
      m_word    = cand;
      m_e++;
   endtask

   task automatic check_all();
      chk("locked",    locked,    x_locked);
      chk("out_valid", out_valid, x_valid);
      chk("realign",   realign,   x_realign);
      chk("out",       out,       x_out);
      chk("out_DK",    out_DK,    x_dk);
`ifdef DESER_ERRCNT_EN
      chk("err_cnt",   err_cnt,   m_err);
`endif
   endtask

   task automatic tick(input logic d, input logic k);
      @(negedge clk);
      reset = 1'b0; data = d; DK = k;
      @(posedge clk);
      model_step(d, k);
      #1 check_all();
   endtask

   task automatic send_word(input logic [7:0] w, input logic k);
      for (int i = W - 1; i >= 0; i--) tick(w[i], (i == 0) ? k : 1'b0);
   endtask

   task automatic filler(input int n);
      for (int i = 0; i < n; i++) tick(1'($urandom), 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1; data = 1'($urandom); DK = 1'($urandom);
         @(posedge clk);
         model_reset();
      end
      #1 check_all();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();

      do_reset(3);
      chk("rst_out", out, 0);
      chk("rst_out_DK", out_DK, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_realign", realign, 0);

      filler(5);
      send_word(K, 1'b1);
      chk("lock_first_realign", realign, 1);
      send_word(K, 1'b1);
      chk("lock_second_no_realign", realign, 0);
      chk("lock_not_yet", locked, 0);
      send_word(K, 1'b1);
      chk("lock_valid", out_valid, 1);
      chk("lock_word", out, 8'hBC);
      chk("lock_locked", locked, 1);
      send_word(8'h3A, 1'b0);
      chk("data_valid", out_valid, 1);
      chk("data_word", out, 8'h3A);
      chk("data_dk", out_DK, 0);

      send_word(K, 1'b1);
      filler(2);
      send_word(K, 1'b1);
      chk("loss_first_miss_locked", locked, 1);
      send_word(K, 1'b1);
      chk("loss_locked", locked, 0);
      chk("loss_realign", realign, 1);
`ifdef DESER_ERRCNT_EN
      chk("loss_err_cnt", err_cnt, 1);
`endif
      send_word(K, 1'b1);
      send_word(K, 1'b1);
      chk("relock", locked, 1);

      filler(3);
      send_word(K, 1'b1);
      chk("missclr_after_first", locked, 1);
      filler(5);
      send_word(K, 1'b1);
      chk("missclr_aligned_valid", out_valid, 1);
      filler(3);
      send_word(K, 1'b1);
      chk("missclr_still_locked", locked, 1);

      filler(3);
      do_reset(1);
      chk("midrst_locked", locked, 0);
      chk("midrst_out", out, 0);
      chk("midrst_valid", out_valid, 0);

      for (int i = 0; i < 4; i++) send_word(K, 1'b0);
      chk("dk_gate_realign", realign, 0);
      chk("dk_gate_locked", locked, 0);

      send_word(K, 1'b1);
      chk("chk_first_realign", realign, 1);
      filler(3);
      send_word(K, 1'b1);
      chk("chk_shift_realign", realign, 1);
      send_word(K, 1'b1);
      chk("chk_hits_restart", locked, 0);
      send_word(K, 1'b1);
      chk("chk_lock", locked, 1);

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(9, 0))
            0, 1, 2, 3: send_word(K, 1'b1);
            4, 5, 6, 7: send_word(8'($urandom), ($urandom_range(3, 0) == 0));
            8:          filler($urandom_range(7, 1));
            default:    send_word(K, 1'b0);
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
